// File: rtl/slave_pkt_pkg.sv
// ---------------------------------------------------------------------------
// slave_pkt_pkg
// Shared types, default parameters and the packet-length clamp helper for
// the MCDF channel slave.
// ---------------------------------------------------------------------------
package slave_pkt_pkg;

    localparam int DEF_DW    = 32;
    localparam int DEF_DEPTH = 32;
    localparam int DEF_LEN_W = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        SEND = 2'd2
    } slv_state_e;

    // A programmed length of 0 still moves one word; anything longer than
    // the FIFO is capped so a request can always be satisfied.
    function automatic int eff_len(input int len, input int depth);
        if (len == 0)
            return 1;
        else if (len > depth)
            return depth;
        else
            return len;
    endfunction

endpackage

// File: rtl/slave_pkt_if.sv
// ---------------------------------------------------------------------------
// slave_pkt_if
// Bundles the channel handshake, register-side config/readback and the
// arbiter request/burst signals of one channel slave.
//   chx_data_i/chx_valid_i/chx_ready_o : channel write port
//   slvx_en_i/pkt_len_i/margin_o       : register block side
//   slvx_req_o/a2sx_ack_i              : arbiter request/grant
//   slvx_data_o/slvx_val_o             : burst output to arbiter
// Signal suffixes are from the slave's point of view.
// ---------------------------------------------------------------------------
interface slave_pkt_if
    import slave_pkt_pkg::*;
#(
    parameter int DW    = DEF_DW,
    parameter int LEN_W = DEF_LEN_W,
    parameter int CNT_W = $clog2(DEF_DEPTH + 1)
) ();

    logic [DW-1:0]    chx_data_i;
    logic             chx_valid_i;
    logic             chx_ready_o;
    logic             slvx_en_i;
    logic [LEN_W-1:0] pkt_len_i;
    logic [CNT_W-1:0] margin_o;
    logic             slvx_req_o;
    logic             a2sx_ack_i;
    logic [DW-1:0]    slvx_data_o;
    logic             slvx_val_o;

    modport slave (
        input  chx_data_i, chx_valid_i, slvx_en_i, pkt_len_i, a2sx_ack_i,
        output chx_ready_o, margin_o, slvx_req_o, slvx_data_o, slvx_val_o
    );

    modport master (
        output chx_data_i, chx_valid_i, slvx_en_i, pkt_len_i, a2sx_ack_i,
        input  chx_ready_o, margin_o, slvx_req_o, slvx_data_o, slvx_val_o
    );

endinterface

// File: rtl/slave_pkt_fifo_core.sv
// ---------------------------------------------------------------------------
// slave_pkt_fifo_core
// Word FIFO for the channel slave: storage, wrapping pointers and occupancy.
//   clk_i, rst_i : clock, async active-high reset (pointers/count only)
//   i_push/i_wdata : write strobe and data
//   i_pop          : advance read pointer
//   o_rdata        : current head word (combinational)
//   o_count        : stored words, 0..DEPTH
// Caller guarantees no push when full and no pop when empty.
// ---------------------------------------------------------------------------
module slave_pkt_fifo_core #(
    parameter int DW    = 32,
    parameter int DEPTH = 32,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             i_push,
    input  logic [DW-1:0]    i_wdata,
    input  logic             i_pop,
    output logic [DW-1:0]    o_rdata,
    output logic [CNT_W-1:0] o_count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DW-1:0]    r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is not reset; contents are meaningless once pointers clear.
    always_ff @(posedge clk_i) begin
        if (i_push)
            r_mem[r_wr_ptr] <= i_wdata;
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/slave_pkt.sv
// ---------------------------------------------------------------------------
// slave_pkt
// MCDF channel slave. Buffers channel words, requests the arbiter once a
// programmable packet length is stored, then emits that packet as a
// back-to-back burst after the grant.
//   clk_i : clock (rising edge)
//   rst_i : asynchronous active-high reset
//   bus   : slave_pkt_if.slave (channel port, enable/length/margin, arbiter)
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | collecting words; waits for enable and count >= length
//   REQ   | request held to arbiter, length latched, waiting for ack
//   SEND  | one word popped and presented valid per cycle for L cycles
// ---------------------------------------------------------------------------
module slave_pkt
    import slave_pkt_pkg::*;
#(
    parameter int DW    = DEF_DW,
    parameter int DEPTH = DEF_DEPTH,
    parameter int LEN_W = DEF_LEN_W
) (
    input  logic       clk_i,
    input  logic       rst_i,
    slave_pkt_if.slave bus
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    slv_state_e       r_state;
    slv_state_e       w_state_nxt;
    logic [CNT_W-1:0] r_len;
    logic [CNT_W-1:0] r_beat;

    logic             w_ready;
    logic             w_push;
    logic             w_pop;
    logic             w_last;
    logic [CNT_W-1:0] w_count;
    logic [CNT_W-1:0] w_len_eff;
    logic [DW-1:0]    w_head;

    assign w_len_eff = CNT_W'(eff_len(int'(bus.pkt_len_i), DEPTH));
    assign w_ready   = bus.slvx_en_i && (w_count < CNT_W'(DEPTH)) && !rst_i;
    assign w_push    = bus.chx_valid_i && w_ready;
    assign w_pop     = (r_state == SEND);
    assign w_last    = (r_beat == r_len - 1'b1);

    slave_pkt_fifo_core #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .i_push  (w_push),
        .i_wdata (bus.chx_data_i),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_count (w_count)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (bus.slvx_en_i && (w_count >= w_len_eff)) w_state_nxt = REQ;
            REQ:     if (bus.a2sx_ack_i) w_state_nxt = SEND;
            SEND:    if (w_last) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Length is frozen on entry to REQ so register writes cannot reshape
    // a packet that has already been requested.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_len   <= '0;
            r_beat  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == IDLE) && (w_state_nxt == REQ))
                r_len <= w_len_eff;
            if (r_state == SEND)
                r_beat <= w_last ? '0 : r_beat + 1'b1;
        end
    end

    assign bus.chx_ready_o = w_ready;
    assign bus.margin_o    = CNT_W'(DEPTH) - w_count;
    assign bus.slvx_req_o  = (r_state == REQ);
    assign bus.slvx_val_o  = (r_state == SEND);
    assign bus.slvx_data_o = (r_state == SEND) ? w_head : '0;

endmodule

// File: tb/tb_slave_pkt.sv
module tb_slave_pkt;

    localparam int DW    = 32;
    localparam int DEPTH = 32;
    localparam int LEN_W = 6;
    localparam int CNT_W = 6;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;

    slave_pkt_if #(.DW(DW), .LEN_W(LEN_W), .CNT_W(CNT_W)) bus ();

    slave_pkt #(.DW(DW), .DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;

    // Reference model: a plain word queue plus packet bookkeeping.
    logic [31:0] mq[$];
    bit          m_req;
    int          m_left;
    int          m_len;

    logic [31:0] obs[$];
    int          n_push = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic int clampl(input int p);
        if (p == 0) return 1;
        if (p > DEPTH) return DEPTH;
        return p;
    endfunction

    function automatic void m_reset();
        mq.delete();
        m_req  = 1'b0;
        m_left = 0;
        m_len  = 1;
    endfunction

    function automatic bit m_ready();
        return bus.slvx_en_i && (mq.size() < DEPTH) && !rst_i;
    endfunction

    function automatic void m_step();
        bit          push;
        logic [31:0] d;
        int          sz;
        push = bus.chx_valid_i && m_ready();
        d    = bus.chx_data_i;
        sz   = mq.size();
        if (m_left > 0) begin
            m_left--;
            void'(mq.pop_front());
        end else if (m_req) begin
            if (bus.a2sx_ack_i) begin
                m_req  = 1'b0;
                m_left = m_len;
            end
        end else if (bus.slvx_en_i && sz >= clampl(int'(bus.pkt_len_i))) begin
            m_req = 1'b1;
            m_len = clampl(int'(bus.pkt_len_i));
        end
        if (push) mq.push_back(d);
    endfunction

    function automatic void compare();
        logic [31:0] exp_data;
        exp_data = (m_left > 0 && mq.size() > 0) ? mq[0] : 32'h0;
        chk("ready",  bus.chx_ready_o, m_ready());
        chk("margin", bus.margin_o, 64'(DEPTH - mq.size()));
        chk("req",    bus.slvx_req_o, m_req);
        chk("val",    bus.slvx_val_o, m_left > 0);
        chk("data",   bus.slvx_data_o, exp_data);
    endfunction

    initial begin
        m_reset();
        forever begin
            @(negedge clk_i);
            if (rst_i) m_reset();
            compare();
            if (bus.slvx_val_o) obs.push_back(bus.slvx_data_o);
            if (bus.chx_valid_i && bus.chx_ready_o) n_push++;
            @(posedge clk_i);
            if (!rst_i) m_step();
        end
    end

    function automatic logic [31:0] obs_at(input int i);
        return (i < obs.size()) ? obs[i] : 32'hxxxx_xxxx;
    endfunction

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic samp();
        @(negedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        step();
        step();
        rst_i = 1'b0;
        obs.delete();
    endtask

    task automatic wait_req(input int bound);
        int k = 0;
        while (!bus.slvx_req_o && k < bound) begin
            step();
            k++;
        end
        chk("req_wait", bus.slvx_req_o, 1'b1);
    endtask

    task automatic wait_obs(input int n, input int bound);
        int k = 0;
        while (obs.size() < n && k < bound) begin
            step();
            k++;
        end
        chk("burst_wait", obs.size() >= n, 1'b1);
    endtask

    task automatic ack_pulse();
        bus.a2sx_ack_i = 1'b1;
        step();
        bus.a2sx_ack_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] first_w, last_w;
        logic [31:0] nw [4];

        bus.chx_data_i  = '0;
        bus.chx_valid_i = 1'b0;
        bus.slvx_en_i   = 1'b0;
        bus.pkt_len_i   = 6'd4;
        bus.a2sx_ack_i  = 1'b0;

        // 1: reset holds ready low even with valid high; disabled blocks input
        bus.chx_valid_i = 1'b1;
        samp();
        chk("rst_ready",  bus.chx_ready_o, 1'b0);
        chk("rst_margin", bus.margin_o, 32);
        chk("rst_req",    bus.slvx_req_o, 1'b0);
        chk("rst_val",    bus.slvx_val_o, 1'b0);
        step();
        rst_i = 1'b0;
        step();
        samp();
        chk("dis_ready",  bus.chx_ready_o, 1'b0);
        step();
        step();
        samp();
        chk("dis_margin", bus.margin_o, 32);
        bus.chx_valid_i = 1'b0;

        // 2: L=4 packet, request timing and burst contents
        step();
        bus.slvx_en_i = 1'b1;
        bus.pkt_len_i = 6'd4;
        for (int i = 0; i < 4; i++) begin
            bus.chx_data_i  = 32'h00C0_0000 + 32'(i);
            bus.chx_valid_i = 1'b1;
            step();
        end
        bus.chx_valid_i = 1'b0;
        samp();
        chk("req_not_yet", bus.slvx_req_o, 1'b0);
        step();
        samp();
        chk("req_rise", bus.slvx_req_o, 1'b1);
        step();
        step();
        obs.delete();
        ack_pulse();
        wait_obs(4, 20);
        for (int i = 0; i < 4; i++)
            chk("l4_beat", obs_at(i), 32'h00C0_0000 + 32'(i));
        samp();
        chk("l4_margin", bus.margin_o, 32);

        // 3: fill to full with clamped length, late length change ignored
        do_reset();
        bus.slvx_en_i = 1'b1;
        bus.pkt_len_i = 6'd40;
        first_w = 32'h0;
        last_w  = 32'h0;
        for (int i = 0; i < DEPTH; i++) begin
            bus.chx_data_i  = $urandom;
            bus.chx_valid_i = 1'b1;
            if (i == 0) first_w = bus.chx_data_i;
            last_w = bus.chx_data_i;
            step();
        end
        bus.chx_valid_i = 1'b1;
        samp();
        chk("full_ready",  bus.chx_ready_o, 1'b0);
        chk("full_margin", bus.margin_o, 0);
        wait_req(5);
        bus.pkt_len_i = 6'd3;
        for (int i = 0; i < 4; i++) step();
        obs.delete();
        ack_pulse();
        bus.chx_valid_i = 1'b0;
        wait_obs(DEPTH, 60);
        step();
        chk("full_count", obs.size(), DEPTH);
        chk("full_first", obs_at(0), first_w);
        chk("full_last",  obs_at(DEPTH - 1), last_w);

        // 4: L=0 -> single-beat packets, random traffic across pointer wrap
        do_reset();
        bus.slvx_en_i = 1'b1;
        bus.pkt_len_i = 6'd0;
        n_push = 0;
        for (int i = 0; i < 600; i++) begin
            bus.chx_valid_i = 1'($urandom_range(0, 1));
            bus.chx_data_i  = $urandom;
            bus.a2sx_ack_i  = 1'($urandom_range(0, 1));
            step();
        end
        bus.chx_valid_i = 1'b0;
        bus.a2sx_ack_i  = 1'b0;
        chk("wrap_pushes", n_push >= 3 * DEPTH, 1'b1);

        // 5: enable dropped mid-burst, burst completes, then resumes
        do_reset();
        bus.slvx_en_i = 1'b1;
        bus.pkt_len_i = 6'd8;
        for (int i = 0; i < 8; i++) begin
            bus.chx_data_i  = $urandom;
            bus.chx_valid_i = 1'b1;
            step();
        end
        bus.chx_valid_i = 1'b0;
        wait_req(5);
        obs.delete();
        ack_pulse();
        wait_obs(2, 10);
        bus.slvx_en_i   = 1'b0;
        bus.chx_valid_i = 1'b1;
        bus.chx_data_i  = $urandom;
        wait_obs(8, 20);
        samp();
        chk("dis_burst_len", obs.size(), 8);
        chk("dis_ready2",    bus.chx_ready_o, 1'b0);
        for (int i = 0; i < 4; i++) step();
        samp();
        chk("dis_no_req",    bus.slvx_req_o, 1'b0);
        step();
        bus.slvx_en_i = 1'b1;
        wait_req(20);
        obs.delete();
        ack_pulse();
        wait_obs(8, 20);
        bus.chx_valid_i = 1'b0;
        step();
        chk("resume_len", obs.size(), 8);

        // 6: reset mid-burst aborts and discards buffered words
        do_reset();
        bus.slvx_en_i = 1'b1;
        bus.pkt_len_i = 6'd4;
        for (int i = 0; i < 6; i++) begin
            bus.chx_data_i  = 32'hDEAD_0000 + 32'(i);
            bus.chx_valid_i = 1'b1;
            step();
        end
        bus.chx_valid_i = 1'b0;
        wait_req(5);
        obs.delete();
        ack_pulse();
        wait_obs(2, 10);
        rst_i = 1'b1;
        samp();
        chk("abort_val",    bus.slvx_val_o, 1'b0);
        chk("abort_data",   bus.slvx_data_o, 32'h0);
        chk("abort_margin", bus.margin_o, 32);
        step();
        rst_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            nw[i] = 32'hE000_0000 + $urandom_range(0, 16'hFFFF);
            bus.chx_data_i  = nw[i];
            bus.chx_valid_i = 1'b1;
            step();
        end
        bus.chx_valid_i = 1'b0;
        wait_req(5);
        obs.delete();
        ack_pulse();
        wait_obs(4, 20);
        for (int i = 0; i < 4; i++)
            chk("post_rst_beat", obs_at(i), nw[i]);

        for (int i = 0; i < 4; i++) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
